// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the single-cycle core's load/store into a req/ack bus access, stalling the core meanwhile.
// Optional one-entry posted-write buffer enabled by defining DMEM_WBUF_EN.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CW      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
`ifdef DMEM_WBUF_EN
    , WPOST
`endif
  } state_t;

  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req;
  logic          we;
  logic          aligned;
  logic          tmo_hit;

  assign req     = memread | memwrite;
  assign we      = memwrite;
  assign aligned = (addr[1:0] == 2'b00);
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (!aligned) misalign = 1'b1;
`ifdef DMEM_WBUF_EN
            else          stall    = !we;
`else
            else          stall    = 1'b1;
`endif
          end
        end
        BUSY:  stall = 1'b1;
`ifdef DMEM_WBUF_EN
        WPOST: stall = req;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      readdata  <= '0;
      buserr    <= 1'b0;
    end else begin
      buserr <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= we;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= writedata;
`ifdef DMEM_WBUF_EN
            state     <= we ? WPOST : BUSY;
`else
            state     <= BUSY;
`endif
          end
        end
        // An ack arriving on the last permitted cycle wins over the timeout.
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) readdata <= bus_rdata;
            state   <= DONE;
          end else if (tmo_hit) begin
            bus_req  <= 1'b0;
            buserr   <= 1'b1;
            readdata <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
`ifdef DMEM_WBUF_EN
        WPOST: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
            buserr  <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, reset/abort sequences and randomized accesses.
module tb_dmem_bridge;

  localparam int TB_TO = 4;
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, writedata, readdata;
  logic        stall, misalign, buserr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_bridge #(.TIMEOUT(TB_TO), .CW(3)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .stall(stall), .misalign(misalign), .buserr(buserr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          ack;
    logic [31:0] rdat;
    int          e_stall;
    int          e_req;
    logic        e_mis;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plays core and memory for one instruction; ack_at is the bus_req cycle on which memory answers.
  task automatic run_access(input vec_t v, input string tag);
    int   stalls = 0, reqs = 0, pulses = 0, cyc = 0;
    bit   prev_req = 0, bad_bus = 0, done = 0;
    logic mis_seen = 0, err_seen = 0;
    logic [31:0] rd_seen = '0;
    logic [31:0] a;
    a = v.a;
    memread = v.rd; memwrite = v.wr; addr = v.a; writedata = v.wd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req === 1'b1) begin
        reqs++;
        if (!prev_req) pulses++;
        if (bus_we !== v.wr || bus_addr !== {a[31:2], 2'b00} || bus_wdata !== v.wd) bad_bus = 1;
        if (reqs == v.ack) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdat;
        end
      end
      prev_req = (bus_req === 1'b1);
      if (stall === 1'b1) stalls++;
      else begin
        done     = 1;
        mis_seen = misalign;
        rd_seen  = readdata;
        err_seen = buserr;
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_stalls"},  stalls, v.e_stall);
    chk({tag, "_reqcyc"},  reqs, v.e_req);
    chk({tag, "_pulses"},  pulses, (v.e_req > 0) ? 1 : 0);
    chk({tag, "_busflds"}, 32'(bad_bus), 32'd0);
    chk({tag, "_misalign"}, 32'(mis_seen), 32'(v.e_mis));
    chk({tag, "_buserr"},  32'(err_seen), 32'(v.e_err));
    chk({tag, "_rdata"},   rd_seen, v.e_rd);
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    chk({tag, "_noreissue"},  32'(bus_req), 32'd0);
    chk({tag, "_errpulse"},   32'(buserr), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk({tag, "_strayack_rd"},  readdata, v.e_rd);
    chk({tag, "_strayack_req"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[9];
  vec_t rv;
  logic [31:0] model_rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h10,       32'h0,        1,  32'hCAFE_F00D, 2, 1, 1'b0, 1'b0, 32'hCAFE_F00D};
    tbl[1] = '{1'b0, 1'b1, 32'h24,       32'h1234_5678, 3, 32'hFFFF_FFFF, 4, 3, 1'b0, 1'b0, 32'hCAFE_F00D};
    tbl[2] = '{1'b1, 1'b0, 32'h13,       32'h0,        1,  32'h1111_1111, 0, 0, 1'b1, 1'b0, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 1'b0, 32'h20,       32'h0,        99, 32'h2222_2222, 5, 4, 1'b0, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h30,       32'h0,        4,  32'h0BAD_BEEF, 5, 4, 1'b0, 1'b0, 32'h0BAD_BEEF};
    tbl[5] = '{1'b1, 1'b1, 32'h08,       32'h55AA_55AA, 2, 32'h3333_3333, 3, 2, 1'b0, 1'b0, 32'h0BAD_BEEF};
    tbl[6] = '{1'b0, 1'b1, 32'h06,       32'h77,       1,  32'h0,         0, 0, 1'b1, 1'b0, 32'h0BAD_BEEF};
    tbl[7] = '{1'b0, 1'b0, 32'h100,      32'h0,        1,  32'h44,        0, 0, 1'b0, 1'b0, 32'h0BAD_BEEF};
    tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,       2,  32'h89AB_CDEF, 3, 2, 1'b0, 1'b0, 32'h89AB_CDEF};

    reset = 1'b0; memread = 1'b1; memwrite = 1'b0; addr = 32'h13; writedata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk);
    chk("rst_misalign", 32'(misalign), 32'd0);
    addr = 32'h10; #1;
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_we",    32'(bus_we), 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_err",   32'(buserr), 32'd0);
    memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (WBUF && tbl[i].wr && tbl[i].a[1:0] == 2'b00) continue;
      run_access(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a bus access, then a late ack.
    memread = 1'b1; addr = 32'h50; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mid_stall0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy_req", 32'(bus_req), 32'd1);
    reset = 1'b0; #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_mis",   32'(misalign), 32'd0);
    @(posedge clk); #1;
    chk("mid_req_off", 32'(bus_req), 32'd0);
    chk("mid_no_err",  32'(buserr), 32'd0);
    reset = 1'b1; memread = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_req",   32'(bus_req), 32'd0);
    chk("late_ack_err",   32'(buserr), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_rd",    readdata, 32'd0);
    @(posedge clk); #1;

    // Randomized accesses against a transaction-level model.
    model_rd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      rv.rd   = $urandom_range(0, 1);
      rv.wr   = WBUF ? 1'b0 : 1'($urandom_range(0, 1));
      rv.a    = $urandom;
      if ($urandom_range(0, 3) != 0) rv.a[1:0] = 2'b00;
      rv.wd   = $urandom;
      rv.ack  = $urandom_range(1, TB_TO + 2);
      rv.rdat = $urandom;
      rv.e_mis = 1'b0; rv.e_err = 1'b0; rv.e_stall = 0; rv.e_req = 0;
      if (rv.rd || rv.wr) begin
        if (rv.a % 4 != 0) rv.e_mis = 1'b1;
        else if (rv.ack > TB_TO) begin
          rv.e_stall = TB_TO + 1; rv.e_req = TB_TO; rv.e_err = 1'b1; model_rd = 32'h0;
        end else begin
          rv.e_stall = rv.ack + 1; rv.e_req = rv.ack;
          if (!rv.wr) model_rd = rv.rdat;
        end
      end
      rv.e_rd = model_rd;
      run_access(rv, $sformatf("rnd%0d", i));
    end

`ifdef DMEM_WBUF_EN
    memread = 1'b0; memwrite = 1'b1; addr = 32'h40; writedata = 32'hAA;
    @(negedge clk);
    chk("wb_wr_nostall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b1; addr = 32'h44;
    @(negedge clk);
    chk("wb_rd_stall1", 32'(stall), 32'd1);
    chk("wb_req",       32'(bus_req), 32'd1);
    chk("wb_we",        32'(bus_we), 32'd1);
    chk("wb_addr",      bus_addr, 32'h40);
    chk("wb_wdata",     bus_wdata, 32'hAA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_rd_stall2", 32'(stall), 32'd1);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("wb_req_gap",   32'(bus_req), 32'd0);
    chk("wb_rd_stall3", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_rd_req",  32'(bus_req), 32'd1);
    chk("wb_rd_we",   32'(bus_we), 32'd0);
    chk("wb_rd_addr", bus_addr, 32'h44);
    bus_ack = 1'b1; bus_rdata = 32'h600D_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("wb_rd_done",  32'(stall), 32'd0);
    chk("wb_rd_rdata", readdata, 32'h600D_F00D);
    @(posedge clk); #1;
    memread = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the single-cycle datapath. It consumes the datapath's ALU result (address), store data and memread/memwrite controls, and returns load data.
- Converts the single-cycle core's combinational memory access into a req/ack handshake toward a multi-cycle data memory or bus. Asserts stall to freeze the core (PC and register-file writes) until the access completes.
- Adds misalignment detection and an ack timeout.

Parameters:
- TIMEOUT, 256: max cycles bus_req may stay high without bus_ack before abort; 0 disables the timeout.
- CW, 9: timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge)
- memread  in  1  core load request (current instruction)
- memwrite  in  1  core store request (current instruction)
- addr  in  32  byte address (datapath aluout)
- writedata  in  32  store data
- readdata  out  32  load data returned to core
- stall  out  1  combinational; 1 = core must hold PC and suppress regwrite this cycle
- misalign  out  1  combinational; 1 = current request has addr[1:0]!=0 and was dropped
- buserr  out  1  registered, 1-cycle pulse on timeout abort
- bus_req  out  1  registered request to memory
- bus_we  out  1  registered; 1 = write
- bus_addr  out  32  registered word address {addr[31:2],2'b00}
- bus_wdata  out  32  registered store data
- bus_rdata  in  32  memory read data, valid with bus_ack
- bus_ack  in  1  memory completion, single-cycle pulse

Behaviour:
- Reset (reset=0): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdata=0, buserr=0, timeout count=0. stall=0 and misalign=0 while reset=0.
- A request exists when memread|memwrite. If both are set, it is treated as a write.
- IDLE:
  - With an aligned request: latch addr, writedata and we into the bus_* registers; bus_req=1 next cycle; go to BUSY. stall=1 this cycle.
  - With a misaligned request: misalign=1, stall=0, no bus transaction, state stays IDLE, readdata unchanged.
  - With no request: stall=0.
- BUSY:
  - stall=1. bus_req, bus_we, bus_addr and bus_wdata are held stable until ack or abort.
  - Timeout counter increments each cycle.
  - On bus_ack: bus_req=0 next cycle. If it was a read, readdata<=bus_rdata. Go to DONE.
  - If TIMEOUT!=0 and the count reaches TIMEOUT-1 without ack: bus_req=0, buserr pulses next cycle, readdata<=0, go to DONE.
- DONE:
  - stall=0. Core completes the instruction at this edge with readdata valid.
  - Return to IDLE unconditionally. The still-asserted memread/memwrite of the same instruction is not reissued.
  - Counter cleared.
- Latency: aligned access with ack on the first BUSY cycle = 2 stall cycles, completing in the 3rd cycle. Each further ack-wait cycle adds 1.
- bus_ack outside BUSY (stray, or arriving after reset/abort) is ignored.
- Reset mid-BUSY: transaction abandoned, bus_req=0 after the edge, no buserr.

Optional Feature:
- Macro: DMEM_WBUF_EN (one-entry posted-write buffer).
- Defined:
  - Aligned write in IDLE: latch it, stall=0, go to WPOST with bus_req=1 and bus_we=1. The core proceeds immediately.
  - In WPOST: stall = (memread|memwrite). On bus_ack, go to IDLE; a pending core request is then processed normally from IDLE on the next cycle.
  - Timeout in WPOST: buserr pulse, go to IDLE.
  - Reads never bypass the buffer.
- Undefined: writes follow the IDLE->BUSY->DONE path with stalls; WPOST does not exist.

Test Plan:
- Aligned read, addr=0x0000_0010, bus_ack 1 cycle after bus_req, bus_rdata=0xCAFE_F00D -> stall high 2 cycles; bus_addr=0x10, bus_we=0; readdata=0xCAFEF00D in DONE; single bus_req pulse.
- Aligned write, addr=0x24, writedata=0x1234_5678, ack after 3 cycles -> stall 4 cycles; bus_we=1; bus_wdata stable 0x12345678 throughout req.
- Read at addr=0x0000_0013 -> misalign=1 same cycle; stall=0; bus_req stays 0; readdata unchanged.
- TIMEOUT=4, no ack -> bus_req high exactly 4 cycles; buserr 1-cycle pulse; readdata=0; core released in DONE.
- reset=0 asserted during BUSY, then ack arrives 2 cycles later -> bus_req=0 after the edge; late ack ignored; state IDLE; no buserr.
- DMEM_WBUF_EN: write 0xAA at 0x40, then immediate read at 0x44, ack after 2 cycles -> no stall on the write; read stalls until write ack, then a separate read transaction is issued.
